branch_predictor_bht: RTL and testbench
=======================================

# branch_predictor_bht

Dynamic branch predictor for the 5-stage RISC-V pipeline. It pairs a bimodal table of 2-bit saturating counters with a tagged branch target buffer (BTB).
- **IF stage:** the block produces `prediction_IF` and `target_IF` for the fetch PC.
- **EX stage:** it consumes each resolved conditional branch and trains itself. This is the same resolution the hazard unit compares against `prediction_EX` to raise `misprediction`.
- **Statistics:** it keeps saturating branch and misprediction counters for performance evaluation.

## Interface
Parameters:
- `ENTRIES`, default 16: number of table entries. Power of two, minimum 4.
- `STAT_W`, default 32: width of the statistics counters.

Ports:
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `pc_IF` input 32: fetch PC to predict.
- `prediction_IF` output 1: predicted taken.
- `target_IF` output 32: predicted target. Valid only when `prediction_IF`=1, otherwise 0.
- `branch_EX` input 1: a conditional branch is resolving in EX this cycle.
- `pc_EX` input 32: PC of the resolving branch.
- `btaken_EX` input 1: actual branch outcome.
- `target_EX` input 32: computed branch target.
- `misprediction` input 1: from the hazard unit. Meaningful only when `branch_EX`=1.
- `stall` input 1: pipeline stall. When high, EX-side updates are suppressed.
- `branch_cnt` output STAT_W: resolved conditional branches.
- `mispredict_cnt` output STAT_W: mispredicted conditional branches.

## Operation
Derived widths:
- IDX = log2(ENTRIES)
- TAG_W = 30 − IDX
- index = pc[IDX+1:2]
- tag = pc[31:IDX+2]
- pc[1:0] is ignored.

Per-entry state: `valid`, `tag`, `target` (32 bits), `ctr` (2 bits). Counter encoding: SNT=00, WNT=01, WT=10, ST=11.

Lookup (combinational from registered state):
- `prediction_IF` = valid[i] & (tag[i]==tag(pc_IF)) & ctr[i][1].
- `target_IF` = target[i] when predicting, otherwise 0.

Update is applied at the clock edge when `branch_EX` & !`stall`. With j = index(pc_EX):
- **Tag hit** (valid & tag match):
  - taken: ctr saturating increment (11 stays 11).
  - not taken: ctr saturating decrement (00 stays 00).
  - taken: target[j] ← target_EX. This handles a changed target.
- **Tag miss or invalid, taken:** allocate the entry, overwriting any alias. Set valid=1, tag=tag(pc_EX), target=target_EX, ctr=WT.
- **Tag miss or invalid, not taken:** no table change. Aliased entries are not evicted.

Statistics, updated under the same enable:
- `branch_cnt` += 1.
- `mispredict_cnt` += `misprediction`.
- Both saturate at all-ones and never wrap.

`jal`/`jalr` are not handled by this block.

## Timing
- **Reset:** asserted asynchronously.
  - All valid=0, all ctr=WNT, all tags and targets = 0.
  - Both statistics counters = 0.
  - Outputs during and right after reset: `prediction_IF`=0, `target_IF`=0.
- **Lookup latency:** 0 cycles. Combinational from `pc_IF`.
- **Update latency:** takes effect at the edge at the end of the EX cycle. It is visible to lookups from the next cycle.
- **Same-cycle read/write of the same index:** the lookup sees the old state. There is no write-to-read bypass.
- **Stall high with `branch_EX` high:** no update and no count. The branch re-presents next cycle and is counted exactly once.
- **Reset asserted mid-operation:** any update in flight is discarded. The tables are cleared immediately, without waiting for a clock edge.

## Structure
- Package `bp_pkg` holds:
  - `typedef logic [1:0] bp_ctr_t` and constants `BP_SNT`, `BP_WNT`, `BP_WT`, `BP_ST`.
  - Entry struct `bp_entry_t` {valid, tag, target, ctr}. Tag width is parameterised via the module, so the struct has a max-width tag or is defined in the module.
- Sub-module `bp_sat_ctr2`: combinational next-state for the 2-bit counter, inputs ctr and taken. Instantiated once on the update path.
- The table is a flop array with async clear. It is not inferred RAM, because reset must clear it.

## Test plan
1. **Reset:** assert `rst_n`=0 mid-run → `prediction_IF`=0 for any PC, `branch_cnt`=`mispredict_cnt`=0.
2. **Allocate:** resolve pc_EX=0x100, taken, target 0x80. Next cycle pc_IF=0x100 → prediction 1, target 0x80. Counter is WT.
3. **Saturation and hysteresis:** taken twice more at 0x100 (ctr ST), then not-taken once → still predicts taken. A second not-taken → ctr WNT, prediction 0.
4. **Aliasing** (ENTRIES=16): taken at 0x100 allocates, then pc_EX=0x140 resolves.
   - not taken → 0x100 entry intact.
   - taken → 0x100 lookup now misses (prediction 0), 0x140 hits.
5. **Stall:** `branch_EX`=1 with `stall`=1 for 3 cycles, then `stall`=0 → exactly one update, `branch_cnt` += 1.
6. **Statistics:** 10 branches, of which 4 have `misprediction`=1 → `branch_cnt`=10, `mispredict_cnt`=4. With STAT_W=4, the 16th+ branch holds `branch_cnt` at 15.

Source files
------------

// File: rtl/bp_pkg.sv
// bp_pkg: shared types and constants for the bimodal branch predictor with BTB.
package bp_pkg;
    typedef logic [1:0] bp_ctr_t;
    localparam bp_ctr_t BP_SNT = 2'b00;
    localparam bp_ctr_t BP_WNT = 2'b01;
    localparam bp_ctr_t BP_WT  = 2'b10;
    localparam bp_ctr_t BP_ST  = 2'b11;
    // Widest tag occurs at the minimum table size of 4 entries (30 - 2).
    localparam int BP_TAG_MAX = 28;
    typedef struct packed {
        logic                  valid;
        logic [BP_TAG_MAX-1:0] tag;
        logic [31:0]           target;
        bp_ctr_t               ctr;
    } bp_entry_t;
    localparam bp_entry_t BP_ENTRY_RST = '{valid: 1'b0, tag: '0, target: '0, ctr: BP_WNT};
endpackage

// File: rtl/bp_sat_ctr2.sv
// bp_sat_ctr2: next state of a 2-bit saturating taken/not-taken counter.
module bp_sat_ctr2
    import bp_pkg::*;
(
    input  bp_ctr_t ctr_i,
    input  logic    taken_i,
    output bp_ctr_t ctr_o
);
    always_comb begin
        ctr_o = taken_i ? ((ctr_i == BP_ST)  ? BP_ST  : bp_ctr_t'(ctr_i + 2'd1))
                        : ((ctr_i == BP_SNT) ? BP_SNT : bp_ctr_t'(ctr_i - 2'd1));
    end
endmodule

// File: rtl/branch_predictor_bht.sv
// branch_predictor_bht: bimodal 2-bit counter table with tagged BTB, trained from EX,
// plus saturating branch / misprediction statistics.
module branch_predictor_bht
    import bp_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int STAT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       pc_IF,
    output logic              prediction_IF,
    output logic [31:0]       target_IF,
    input  logic              branch_EX,
    input  logic [31:0]       pc_EX,
    input  logic              btaken_EX,
    input  logic [31:0]       target_EX,
    input  logic              misprediction,
    input  logic              stall,
    output logic [STAT_W-1:0] branch_cnt,
    output logic [STAT_W-1:0] mispredict_cnt
);
    localparam int IDX = $clog2(ENTRIES);

    bp_entry_t             tbl_q [ENTRIES];
    bp_entry_t             tbl_d [ENTRIES];
    logic [STAT_W-1:0]     branch_cnt_q, branch_cnt_d;
    logic [STAT_W-1:0]     mispredict_cnt_q, mispredict_cnt_d;
    logic [IDX-1:0]        idx_if, idx_ex;
    logic [BP_TAG_MAX-1:0] tag_if, tag_ex;
    bp_entry_t             ent_if, ent_ex;
    logic                  hit_ex, upd;
    bp_ctr_t               ctr_nxt;

    // Tags are stored zero-extended to the package's maximum width.
    assign idx_if = pc_IF[IDX+1:2];
    assign idx_ex = pc_EX[IDX+1:2];
    assign tag_if = BP_TAG_MAX'(pc_IF >> (IDX + 2));
    assign tag_ex = BP_TAG_MAX'(pc_EX >> (IDX + 2));
    assign ent_if = tbl_q[idx_if];
    assign ent_ex = tbl_q[idx_ex];
    assign hit_ex = ent_ex.valid && (ent_ex.tag == tag_ex);
    assign upd    = branch_EX && !stall;

    assign prediction_IF  = ent_if.valid && (ent_if.tag == tag_if) && ent_if.ctr[1];
    assign target_IF      = prediction_IF ? ent_if.target : 32'd0;
    assign branch_cnt     = branch_cnt_q;
    assign mispredict_cnt = mispredict_cnt_q;

    bp_sat_ctr2 u_ctr (
        .ctr_i   (ent_ex.ctr),
        .taken_i (btaken_EX),
        .ctr_o   (ctr_nxt)
    );

    always_comb begin
        tbl_d = tbl_q;
        if (upd && hit_ex) begin
            tbl_d[idx_ex].ctr    = ctr_nxt;
            tbl_d[idx_ex].target = btaken_EX ? target_EX : ent_ex.target;
        end else if (upd && btaken_EX) begin
            tbl_d[idx_ex] = '{valid: 1'b1, tag: tag_ex, target: target_EX, ctr: BP_WT};
        end
        branch_cnt_d     = (upd && branch_cnt_q != '1) ? branch_cnt_q + 1'b1 : branch_cnt_q;
        mispredict_cnt_d = (upd && misprediction && mispredict_cnt_q != '1)
                           ? mispredict_cnt_q + 1'b1 : mispredict_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < ENTRIES; k++) tbl_q[k] <= BP_ENTRY_RST;
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            tbl_q            <= tbl_d;
            branch_cnt_q     <= branch_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end
endmodule

// File: tb/tb_branch_predictor_bht.sv
// tb_branch_predictor_bht: directed plus random stimulus against a table-level reference model.
module tb_branch_predictor_bht;
    localparam int N   = 16;
    localparam int IDX = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_IF, pc_EX, target_EX;
    logic        branch_EX, btaken_EX, misprediction, stall;
    logic        prediction_IF, pred_s;
    logic [31:0] target_IF, tgt_s;
    logic [31:0] branch_cnt, mispredict_cnt;
    logic [3:0]  bcnt_s, mcnt_s;

    always #5 clk = ~clk;

    branch_predictor_bht #(.ENTRIES(N)) dut (
        .clk(clk), .rst_n(rst_n), .pc_IF(pc_IF), .prediction_IF(prediction_IF),
        .target_IF(target_IF), .branch_EX(branch_EX), .pc_EX(pc_EX), .btaken_EX(btaken_EX),
        .target_EX(target_EX), .misprediction(misprediction), .stall(stall),
        .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
    );

    branch_predictor_bht #(.ENTRIES(N), .STAT_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .pc_IF(pc_IF), .prediction_IF(pred_s),
        .target_IF(tgt_s), .branch_EX(branch_EX), .pc_EX(pc_EX), .btaken_EX(btaken_EX),
        .target_EX(target_EX), .misprediction(misprediction), .stall(stall),
        .branch_cnt(bcnt_s), .mispredict_cnt(mcnt_s)
    );

    int vectors = 0;
    int errors  = 0;

    bit          m_valid [N];
    longint      m_tag   [N];
    logic [31:0] m_tgt   [N];
    int          m_ctr   [N];
    longint      m_br, m_mis;

    function automatic int ix(logic [31:0] pc);
        return int'((pc >> 2) % N);
    endfunction

    function automatic longint tg(logic [31:0] pc);
        return longint'(pc >> (2 + IDX));
    endfunction

    function automatic bit m_pred(logic [31:0] pc);
        return m_valid[ix(pc)] && m_tag[ix(pc)] == tg(pc) && m_ctr[ix(pc)] >= 2;
    endfunction

    function automatic longint sat15(longint v);
        return v > 15 ? 15 : v;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
        end
        m_br = 0; m_mis = 0;
    endtask

    task automatic m_update(logic [31:0] pc, bit tk, logic [31:0] tgt, bit mis);
        int i = ix(pc);
        if (m_valid[i] && m_tag[i] == tg(pc)) begin
            m_ctr[i] = tk ? (m_ctr[i] == 3 ? 3 : m_ctr[i] + 1) : (m_ctr[i] == 0 ? 0 : m_ctr[i] - 1);
            if (tk) m_tgt[i] = tgt;
        end else if (tk) begin
            m_valid[i] = 1; m_tag[i] = tg(pc); m_tgt[i] = tgt; m_ctr[i] = 2;
        end
        m_br++;
        if (mis) m_mis++;
    endtask

    task automatic chk(string t, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", t, obs, exp);
        end
    endtask

    task automatic check_all(string t);
        bit p = m_pred(pc_IF);
        chk({t, "/pred"},   32'(prediction_IF), 32'(p));
        chk({t, "/target"}, target_IF, p ? m_tgt[ix(pc_IF)] : 32'd0);
        chk({t, "/bcnt"},   branch_cnt, 32'(m_br));
        chk({t, "/mcnt"},   mispredict_cnt, 32'(m_mis));
        chk({t, "/bcnt4"},  32'(bcnt_s), 32'(sat15(m_br)));
        chk({t, "/mcnt4"},  32'(mcnt_s), 32'(sat15(m_mis)));
    endtask

    // Drive one cycle's inputs, check the pre-edge lookup, then commit the edge in the model.
    task automatic cyc(string t, bit b, logic [31:0] pcx, bit tk, logic [31:0] tgt,
                       bit mis, bit st, logic [31:0] pcf);
        branch_EX = b; pc_EX = pcx; btaken_EX = tk; target_EX = tgt;
        misprediction = mis; stall = st; pc_IF = pcf;
        #1;
        check_all(t);
        @(posedge clk);
        if (b && !st) m_update(pcx, tk, tgt, mis);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        m_reset();
        chk("reset/pred", 32'(prediction_IF), 32'd0);
        chk("reset/bcnt", branch_cnt, 32'd0);
        check_all("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] b0;
        rst_n = 1'b0; branch_EX = 0; pc_EX = 0; btaken_EX = 0; target_EX = 0;
        misprediction = 0; stall = 0; pc_IF = 0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        cyc("alloc", 1, 32'h100, 1, 32'h80, 0, 0, 32'h100);
        cyc("alloc_look", 0, 0, 0, 0, 0, 0, 32'h100);
        chk("alloc/pred", 32'(prediction_IF), 32'd1);
        chk("alloc/target", target_IF, 32'h80);

        cyc("sat1", 1, 32'h100, 1, 32'h80, 0, 0, 32'h100);
        cyc("sat2", 1, 32'h100, 1, 32'h80, 0, 0, 32'h100);
        cyc("hyst1", 1, 32'h100, 0, 32'h0, 1, 0, 32'h100);
        chk("hyst1/pred", 32'(prediction_IF), 32'd1);
        cyc("hyst2", 1, 32'h100, 0, 32'h0, 1, 0, 32'h100);
        chk("hyst2/pred", 32'(prediction_IF), 32'd0);

        // Mid-run reset with a branch presented: the update must be discarded.
        branch_EX = 1; pc_EX = 32'h104; btaken_EX = 1; target_EX = 32'h44;
        do_reset();
        cyc("after_rst", 0, 0, 0, 0, 0, 0, 32'h104);
        chk("after_rst/pred", 32'(prediction_IF), 32'd0);

        cyc("alias_a", 1, 32'h100, 1, 32'h80, 0, 0, 32'h100);
        cyc("alias_nt", 1, 32'h140, 0, 32'h0, 0, 0, 32'h100);
        chk("alias_nt/pred", 32'(prediction_IF), 32'd1);
        chk("alias_nt/target", target_IF, 32'h80);
        cyc("alias_t", 1, 32'h140, 1, 32'h200, 1, 0, 32'h100);
        chk("alias_t/pred100", 32'(prediction_IF), 32'd0);
        pc_IF = 32'h140;
        #1;
        chk("alias_t/pred140", 32'(prediction_IF), 32'd1);
        chk("alias_t/target140", target_IF, 32'h200);

        b0 = branch_cnt;
        repeat (3) cyc("stall_hi", 1, 32'h180, 1, 32'h300, 0, 1, 32'h180);
        cyc("stall_lo", 1, 32'h180, 1, 32'h300, 0, 0, 32'h180);
        chk("stall/bcnt", branch_cnt, b0 + 32'd1);
        chk("stall/pred", 32'(prediction_IF), 32'd1);

        do_reset();
        for (int i = 0; i < 10; i++) cyc("stats", 1, 32'h200 + 32'(i * 4), 0, 0, i < 4, 0, 32'h0);
        chk("stats/bcnt", branch_cnt, 32'd10);
        chk("stats/mcnt", mispredict_cnt, 32'd4);
        for (int i = 0; i < 6; i++) cyc("stats_sat", 1, 32'h200, 0, 0, 0, 0, 32'h0);
        chk("stats/bcnt16", branch_cnt, 32'd16);
        chk("stats/bcnt4", 32'(bcnt_s), 32'd15);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] px, pf;
            px = ($urandom_range(0, 31) << 2) | ($urandom_range(0, 1) << 12) | $urandom_range(0, 3);
            pf = ($urandom_range(0, 31) << 2) | ($urandom_range(0, 1) << 12) | $urandom_range(0, 3);
            cyc("rand", $urandom_range(0, 3) != 0, px, $urandom_range(0, 2) != 0,
                $urandom, $urandom_range(0, 1), $urandom_range(0, 3) == 0, pf);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
